dmi_arbiter: RTL and testbench
==============================

DMI_ARBITER -- requirements
Module: dmi_arbiter

Interface
REQ-001 Parameter: ABITS, default 7, DMI address width.
REQ-002 Parameter: TIMEOUT, default 255, max clk cycles waiting for a DM response; range 1..65535.
REQ-003 Port: clk  input  1  single clock for all logic.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Ports, per requester n in {0,1}:
  - s_req_valid[n]  input  1
  - s_req_ready[n]  output  1
  - s_req_addr[n]  input  ABITS
  - s_req_data[n]  input  32
  - s_req_op[n]  input  2  (0 nop, 1 read, 2 write, 3 reserved)
REQ-006 Ports, per requester n:
  - s_rsp_valid[n]  output  1
  - s_rsp_ready[n]  input  1
  - s_rsp_data[n]  output  32
  - s_rsp_op[n]  output  2  (0 success, 2 failed)
REQ-007 Ports, DM side:
  - m_req_valid  output  1
  - m_req_ready  input  1
  - m_req_addr  output  ABITS
  - m_req_data  output  32
  - m_req_op  output  2
REQ-008 Ports, DM side:
  - m_rsp_valid  input  1
  - m_rsp_ready  output  1
  - m_rsp_data  input  32
  - m_rsp_op  input  2
REQ-009 Port: busy  output  1  high whenever state is not IDLE.
REQ-010 Port: timeout_err  output  1  sticky; set on any timeout.
REQ-011 Port: timeout_clr  input  1  clears timeout_err.

Function
REQ-012 All handshakes are valid/ready; a transfer occurs on a clk rising edge with both high; valid, once raised, holds with stable payload until transfer.
REQ-013 FSM states: IDLE, ISSUE, WAIT, RESP; at most one transaction outstanding.
REQ-014 IDLE: if any s_req_valid, grant one requester and assert that requester's s_req_ready for exactly one cycle, latching addr/data/op and grant index; all other s_req_ready low.
REQ-015 Arbitration is round-robin: when both are valid, grant the requester not granted last; when one is valid, grant it.
REQ-016 Latched op 1 or 2 -> ISSUE.
REQ-017 Latched op 0 -> RESP with rsp data 0 and op 0; latched op 3 -> RESP with rsp data 0 and op 2; the DM is not accessed in either case.
REQ-018 ISSUE: m_req_valid=1 with latched payload; on m_req_ready -> WAIT and clear the timeout counter.
REQ-019 WAIT: m_rsp_ready=1; on m_rsp_valid, latch m_rsp_data and m_rsp_op (op 3 mapped to 2) -> RESP.
REQ-020 WAIT: the counter increments each cycle without m_rsp_valid; at count==TIMEOUT -> RESP with data 0 and op 2, and set timeout_err.
REQ-021 If m_rsp_valid coincides with count==TIMEOUT, the real response wins and timeout_err is not set.
REQ-022 RESP: s_rsp_valid high only for the granted index, with latched data/op; on s_rsp_ready -> IDLE.
REQ-023 Minimum latency for a read/write, s_req transfer to s_rsp_valid with DM ready and responding immediately: 3 cycles; nop/reserved: 1 cycle.
REQ-024 In IDLE, m_rsp_ready=1 and any m_rsp_valid is discarded, which drains late responses after a timeout.
REQ-025 In states other than WAIT and IDLE, m_rsp_ready=0.
REQ-026 timeout_err: setting takes priority over a simultaneous timeout_clr.

Reset
REQ-027 On rst low, asynchronously:
  - state=IDLE
  - all valid/ready outputs 0
  - busy=0, timeout_err=0
  - counter=0
  - data/op registers 0
  - last-grant=1, so requester 0 wins the first tie.
REQ-028 Reset mid-transaction abandons it with no response.
REQ-029 The first grant is possible on the first clk edge after rst deasserts.

Verification
REQ-030 Requester 0 read, addr 0x11, with the DM answering 0x00400000 op 0 one cycle after m_req transfer -> s_rsp_data[0]=0x00400000, s_rsp_op[0]=0.
REQ-031 Both requesters assert write from reset -> grant order 0,1,0,1 over four back-to-back requests each.
REQ-032 Read with the DM never responding, TIMEOUT=255 -> s_rsp_op=2, data 0, timeout_err=1 exactly 255 cycles after entering WAIT; a later m_rsp_valid in IDLE is consumed and produces no s_rsp_valid.
REQ-033 Nop and op 3 requests -> responses (0, 0) and (0, 2) in 1 cycle; m_req_valid never rises.
REQ-034 Response held with s_rsp_ready=0 for 10 cycles -> payload stable, no new grant; rst pulsed during WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/dmi_arbiter_if.sv
// DMI bus bundle: two requester ports on the arbiter's upstream side plus
// the single debug-module port on its downstream side.
interface dmi_arbiter_if #(
   parameter int unsigned ABITS = 7
) ();
   // requester request channels
   logic [1:0]       s_req_valid;
   logic [1:0]       s_req_ready;
   logic [ABITS-1:0] s_req_addr [2];
   logic [31:0]      s_req_data [2];
   logic [1:0]       s_req_op   [2];

   // requester response channels
   logic [1:0]       s_rsp_valid;
   logic [1:0]       s_rsp_ready;
   logic [31:0]      s_rsp_data [2];
   logic [1:0]       s_rsp_op   [2];

   // debug-module request channel
   logic             m_req_valid;
   logic             m_req_ready;
   logic [ABITS-1:0] m_req_addr;
   logic [31:0]      m_req_data;
   logic [1:0]       m_req_op;

   // debug-module response channel
   logic             m_rsp_valid;
   logic             m_rsp_ready;
   logic [31:0]      m_rsp_data;
   logic [1:0]       m_rsp_op;

   // arbiter view: drives requester responses and the DM request
   modport master (
      input  s_req_valid, s_req_addr, s_req_data, s_req_op, s_rsp_ready,
      input  m_req_ready, m_rsp_valid, m_rsp_data, m_rsp_op,
      output s_req_ready, s_rsp_valid, s_rsp_data, s_rsp_op,
      output m_req_valid, m_req_addr, m_req_data, m_req_op, m_rsp_ready
   );

   // environment view: requesters and the debug module
   modport slave (
      output s_req_valid, s_req_addr, s_req_data, s_req_op, s_rsp_ready,
      output m_req_ready, m_rsp_valid, m_rsp_data, m_rsp_op,
      input  s_req_ready, s_rsp_valid, s_rsp_data, s_rsp_op,
      input  m_req_valid, m_req_addr, m_req_data, m_req_op, m_rsp_ready
   );
endinterface

// File: rtl/dmi_arbiter.sv
// Two-requester round-robin arbiter in front of a single DMI debug module.
// One transaction outstanding at a time; DM responses time out after TIMEOUT
// cycles, and nop/reserved requests are answered locally without touching the DM.
module dmi_arbiter #(
   parameter int unsigned ABITS   = 7,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   dmi_arbiter_if.master bus,
   output logic          busy,
   output logic          timeout_err,
   input  logic          timeout_clr
);

   localparam int unsigned CNT_W = 16;
   localparam int unsigned DW    = 32;

   localparam logic [1:0] OP_NOP   = 2'd0;
   localparam logic [1:0] OP_READ  = 2'd1;
   localparam logic [1:0] OP_WRITE = 2'd2;
   localparam logic [1:0] OP_RSV   = 2'd3;
   localparam logic [1:0] RSP_OK   = 2'd0;
   localparam logic [1:0] RSP_FAIL = 2'd2;

   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       ready_q, ready_d;
   logic             gnt_q, gnt_d;
   logic             last_q, last_d;
   logic [ABITS-1:0] addr_q, addr_d;
   logic [DW-1:0]    data_q, data_d;
   logic [1:0]       op_q, op_d;
   logic [DW-1:0]    rsp_data_q, rsp_data_d;
   logic [1:0]       rsp_op_q, rsp_op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             err_set;
   logic             err_d;
   logic             pick;
   logic [1:0]       req_op_sel;

   // Round-robin pick: on a tie favour the requester not granted last
   assign pick       = (&bus.s_req_valid) ? ~last_q : bus.s_req_valid[1];
   assign req_op_sel = bus.s_req_op[gnt_q];
   assign cnt_inc    = cnt_q + CNT_W'(1);

   // Latched payloads drive the buses directly; valid strobes qualify them
   assign bus.m_req_addr    = addr_q;
   assign bus.m_req_data    = data_q;
   assign bus.m_req_op      = op_q;
   assign bus.s_rsp_data[0] = rsp_data_q;
   assign bus.s_rsp_data[1] = rsp_data_q;
   assign bus.s_rsp_op[0]   = rsp_op_q;
   assign bus.s_rsp_op[1]   = rsp_op_q;

   // Next-state, grant and datapath decisions
   always_comb begin
      state_d    = state_q;
      ready_d    = 2'b00;
      gnt_d      = gnt_q;
      last_d     = last_q;
      addr_d     = addr_q;
      data_d     = data_q;
      op_d       = op_q;
      rsp_data_d = rsp_data_q;
      rsp_op_d   = rsp_op_q;
      cnt_d      = cnt_q;
      err_set    = 1'b0;

      unique case (state_q)
         IDLE: begin
            // ready was raised last cycle; the edge with valid high is the transfer
            if (ready_q != 2'b00) begin
               if (bus.s_req_valid[gnt_q]) begin
                  addr_d     = bus.s_req_addr[gnt_q];
                  data_d     = bus.s_req_data[gnt_q];
                  op_d       = req_op_sel;
                  rsp_data_d = '0;
                  rsp_op_d   = (req_op_sel == OP_RSV) ? RSP_FAIL : RSP_OK;
                  if ((req_op_sel == OP_READ) || (req_op_sel == OP_WRITE)) begin
                     state_d = ISSUE;
                  end else begin
                     state_d = RESP;
                  end
               end
            end else if (|bus.s_req_valid) begin
               gnt_d   = pick;
               last_d  = pick;
               ready_d = pick ? 2'b10 : 2'b01;
            end
         end
         ISSUE: begin
            if (bus.m_req_ready) begin
               state_d = WAIT;
               cnt_d   = '0;
            end
         end
         WAIT: begin
            // a real response beats a timeout landing on the same edge
            if (bus.m_rsp_valid) begin
               rsp_data_d = bus.m_rsp_data;
               rsp_op_d   = (bus.m_rsp_op == OP_RSV) ? RSP_FAIL : bus.m_rsp_op;
               state_d    = RESP;
            end else if (cnt_inc == CNT_LIMIT) begin
               rsp_data_d = '0;
               rsp_op_d   = RSP_FAIL;
               err_set    = 1'b1;
               cnt_d      = cnt_inc;
               state_d    = RESP;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         RESP: begin
            if (bus.s_rsp_ready[gnt_q]) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      err_d = err_set ? 1'b1 : (timeout_clr ? 1'b0 : timeout_err);
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         ready_q    <= 2'b00;
         gnt_q      <= 1'b0;
         last_q     <= 1'b1;
         addr_q     <= '0;
         data_q     <= '0;
         op_q       <= OP_NOP;
         rsp_data_q <= '0;
         rsp_op_q   <= RSP_OK;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_d;
         gnt_q      <= gnt_d;
         last_q     <= last_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         op_q       <= op_d;
         rsp_data_q <= rsp_data_d;
         rsp_op_q   <= rsp_op_d;
         cnt_q      <= cnt_d;
      end
   end

   // Registered handshake and status outputs, decoded from the next state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.s_req_ready <= 2'b00;
         bus.s_rsp_valid <= 2'b00;
         bus.m_req_valid <= 1'b0;
         bus.m_rsp_ready <= 1'b0;
         busy            <= 1'b0;
         timeout_err     <= 1'b0;
      end else begin
         bus.s_req_ready <= ready_d;
         bus.s_rsp_valid <= (state_d == RESP) ? (gnt_d ? 2'b10 : 2'b01) : 2'b00;
         bus.m_req_valid <= (state_d == ISSUE);
         bus.m_rsp_ready <= (state_d == WAIT) || (state_d == IDLE);
         busy            <= (state_d != IDLE);
         timeout_err     <= err_d;
      end
   end

endmodule

// File: tb/tb_dmi_arbiter.sv
// Directed bench for dmi_arbiter: reset values, read/write/nop/reserved paths,
// round-robin order, response back-pressure, timeout and async reset.
`timescale 1ns/1ps
module tb_dmi_arbiter;
   localparam int unsigned ABITS   = 7;
   localparam int unsigned TIMEOUT = 255;

   logic clk = 1'b0;
   logic rst;
   logic busy;
   logic timeout_err;
   logic timeout_clr;
   int   checks      = 0;
   int   failures    = 0;
   int   mreq_cycles = 0;

   dmi_arbiter_if #(.ABITS(ABITS)) bus ();

   dmi_arbiter #(.ABITS(ABITS), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .busy        (busy),
      .timeout_err (timeout_err),
      .timeout_clr (timeout_clr)
   );

   always #5 clk = ~clk;

   // cycles with a DM request on the bus
   always @(negedge clk) begin
      if (bus.m_req_valid) mreq_cycles <= mreq_cycles + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_grant(input int idx, input string tag);
      int n;
      n = 0;
      while (bus.s_req_ready == 2'b00 && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(bus.s_req_ready), (idx == 1) ? 32'd2 : 32'd1);
   endtask

   initial begin
      int          mreq_snap;
      int          g;
      int          sent [2];
      logic [31:0] exp_data;
      logic [31:0] exp_oh;

      rst             = 1'b0;
      timeout_clr     = 1'b0;
      bus.s_req_valid = 2'b00;
      bus.s_rsp_ready = 2'b00;
      bus.m_req_ready = 1'b0;
      bus.m_rsp_valid = 1'b0;
      bus.m_rsp_data  = 32'h0;
      bus.m_rsp_op    = 2'd0;
      for (int i = 0; i < 2; i++) begin
         bus.s_req_addr[i] = '0;
         bus.s_req_data[i] = 32'h0;
         bus.s_req_op[i]   = 2'd0;
      end

      // reset state
      tick(1);
      chk("rst_busy",        32'(busy), 32'd0);
      chk("rst_timeout_err", 32'(timeout_err), 32'd0);
      chk("rst_s_req_ready", 32'(bus.s_req_ready), 32'd0);
      chk("rst_s_rsp_valid", 32'(bus.s_rsp_valid), 32'd0);
      chk("rst_m_req_valid", 32'(bus.m_req_valid), 32'd0);
      chk("rst_m_rsp_ready", 32'(bus.m_rsp_ready), 32'd0);

      // requester 0 read of 0x11, pending across reset release
      bus.s_req_addr[0] = 7'h11;
      bus.s_req_op[0]   = 2'd1;
      bus.s_req_valid   = 2'b01;
      tick(1);
      rst = 1'b1;
      tick(1);
      chk("first_grant",      32'(bus.s_req_ready), 32'd1);
      chk("idle_m_rsp_ready", 32'(bus.m_rsp_ready), 32'd1);
      chk("idle_busy",        32'(busy), 32'd0);
      tick(1);
      bus.s_req_valid = 2'b00;
      bus.m_req_ready = 1'b1;
      chk("grant_one_cycle",   32'(bus.s_req_ready), 32'd0);
      chk("rd_m_req_valid",    32'(bus.m_req_valid), 32'd1);
      chk("rd_m_req_addr",     32'(bus.m_req_addr), 32'h11);
      chk("rd_m_req_op",       32'(bus.m_req_op), 32'd1);
      chk("issue_m_rsp_ready", 32'(bus.m_rsp_ready), 32'd0);
      chk("issue_busy",        32'(busy), 32'd1);
      tick(1);
      bus.m_req_ready = 1'b0;
      chk("wait_m_req_valid", 32'(bus.m_req_valid), 32'd0);
      chk("wait_m_rsp_ready", 32'(bus.m_rsp_ready), 32'd1);
      bus.m_rsp_valid = 1'b1;
      bus.m_rsp_data  = 32'h0040_0000;
      bus.m_rsp_op    = 2'd0;
      tick(1);
      bus.m_rsp_valid = 1'b0;
      chk("rd_s_rsp_valid",   32'(bus.s_rsp_valid), 32'd1);
      chk("rd_s_rsp_data",    bus.s_rsp_data[0], 32'h0040_0000);
      chk("rd_s_rsp_op",      32'(bus.s_rsp_op[0]), 32'd0);
      chk("resp_m_rsp_ready", 32'(bus.m_rsp_ready), 32'd0);
      bus.s_rsp_ready = 2'b01;
      tick(1);
      bus.s_rsp_ready = 2'b00;
      chk("rd_done_valid", 32'(bus.s_rsp_valid), 32'd0);
      chk("rd_done_busy",  32'(busy), 32'd0);

      // nop from requester 1 then reserved op from requester 0, answered locally
      mreq_snap         = mreq_cycles;
      bus.s_req_addr[1] = 7'h05;
      bus.s_req_data[1] = 32'h1234_5678;
      bus.s_req_op[1]   = 2'd0;
      bus.s_req_valid   = 2'b10;
      tick(1);
      chk("nop_grant", 32'(bus.s_req_ready), 32'd2);
      tick(1);
      bus.s_req_valid = 2'b00;
      chk("nop_s_rsp_valid", 32'(bus.s_rsp_valid), 32'd2);
      chk("nop_s_rsp_data",  bus.s_rsp_data[1], 32'h0);
      chk("nop_s_rsp_op",    32'(bus.s_rsp_op[1]), 32'd0);
      bus.s_rsp_ready = 2'b10;
      tick(1);
      bus.s_rsp_ready   = 2'b00;
      bus.s_req_addr[0] = 7'h33;
      bus.s_req_data[0] = 32'hDEAD_BEEF;
      bus.s_req_op[0]   = 2'd3;
      bus.s_req_valid   = 2'b01;
      tick(1);
      chk("rsv_grant", 32'(bus.s_req_ready), 32'd1);
      tick(1);
      bus.s_req_valid = 2'b00;
      chk("rsv_s_rsp_valid", 32'(bus.s_rsp_valid), 32'd1);
      chk("rsv_s_rsp_data",  bus.s_rsp_data[0], 32'h0);
      chk("rsv_s_rsp_op",    32'(bus.s_rsp_op[0]), 32'd2);
      bus.s_rsp_ready = 2'b01;
      tick(1);
      bus.s_rsp_ready = 2'b00;
      chk("local_no_m_req", 32'(mreq_cycles - mreq_snap), 32'd0);

      // requester 1 read; DM answers op 3; response held off for 10 cycles
      bus.s_req_addr[1] = 7'h7F;
      bus.s_req_data[1] = 32'h0;
      bus.s_req_op[1]   = 2'd1;
      bus.s_req_valid   = 2'b10;
      bus.m_req_ready   = 1'b1;
      tick(1);
      chk("hold_grant", 32'(bus.s_req_ready), 32'd2);
      tick(1);
      chk("hold_m_req_valid", 32'(bus.m_req_valid), 32'd1);
      chk("hold_m_req_addr",  32'(bus.m_req_addr), 32'h7F);
      bus.s_req_addr[0] = 7'h22;
      bus.s_req_data[0] = 32'hA5A5_A5A5;
      bus.s_req_op[0]   = 2'd2;
      bus.s_req_valid   = 2'b01;
      tick(1);
      bus.m_req_ready = 1'b0;
      bus.m_rsp_valid = 1'b1;
      bus.m_rsp_data  = 32'hCAFE_F00D;
      bus.m_rsp_op    = 2'd3;
      tick(1);
      bus.m_rsp_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk("hold_s_rsp_valid", 32'(bus.s_rsp_valid), 32'd2);
         chk("hold_s_rsp_data",  bus.s_rsp_data[1], 32'hCAFE_F00D);
         chk("hold_s_rsp_op",    32'(bus.s_rsp_op[1]), 32'd2);
         chk("hold_no_grant",    32'(bus.s_req_ready), 32'd0);
         tick(1);
      end
      bus.s_rsp_ready = 2'b10;
      tick(1);
      bus.s_rsp_ready = 2'b00;
      chk("hold_released", 32'(bus.s_rsp_valid), 32'd0);
      tick(1);
      chk("wr_grant", 32'(bus.s_req_ready), 32'd1);
      tick(1);
      bus.s_req_valid = 2'b00;
      chk("wr_m_req_valid", 32'(bus.m_req_valid), 32'd1);
      chk("wr_m_req_op",    32'(bus.m_req_op), 32'd2);
      chk("wr_m_req_data",  bus.m_req_data, 32'hA5A5_A5A5);
      chk("wr_m_req_addr",  32'(bus.m_req_addr), 32'h22);
      bus.m_req_ready = 1'b1;
      tick(1);
      bus.m_req_ready = 1'b0;
      chk("wr_wait_busy",        32'(busy), 32'd1);
      chk("wr_wait_m_rsp_ready", 32'(bus.m_rsp_ready), 32'd1);

      // asynchronous reset while waiting on the DM
      rst = 1'b0;
      #1;
      chk("arst_busy",        32'(busy), 32'd0);
      chk("arst_m_rsp_ready", 32'(bus.m_rsp_ready), 32'd0);
      chk("arst_m_req_valid", 32'(bus.m_req_valid), 32'd0);
      chk("arst_m_req_addr",  32'(bus.m_req_addr), 32'd0);
      chk("arst_m_req_data",  bus.m_req_data, 32'd0);
      chk("arst_s_rsp_valid", 32'(bus.s_rsp_valid), 32'd0);
      chk("arst_s_req_ready", 32'(bus.s_req_ready), 32'd0);
      tick(1);
      rst = 1'b1;
      tick(3);
      chk("abandon_s_rsp_valid", 32'(bus.s_rsp_valid), 32'd0);
      chk("abandon_busy",        32'(busy), 32'd0);
      chk("abandon_m_req_valid", 32'(bus.m_req_valid), 32'd0);

      // round robin: both requesters issue four writes each
      sent[0]           = 0;
      sent[1]           = 0;
      bus.s_req_op[0]   = 2'd2;
      bus.s_req_op[1]   = 2'd2;
      bus.s_req_addr[0] = 7'h40;
      bus.s_req_addr[1] = 7'h41;
      bus.s_req_data[0] = 32'h1000_0000;
      bus.s_req_data[1] = 32'h2000_0000;
      bus.s_req_valid   = 2'b11;
      bus.m_req_ready   = 1'b1;
      for (int t = 0; t < 8; t++) begin
         g        = t % 2;
         exp_data = 32'h1000_0000 * 32'(g + 1) + 32'(sent[g]);
         exp_oh   = (g == 1) ? 32'd2 : 32'd1;
         wait_grant(g, "rr_grant");
         tick(1);
         sent[g]++;
         if (sent[g] == 4) bus.s_req_valid[g] = 1'b0;
         else bus.s_req_data[g] = 32'h1000_0000 * 32'(g + 1) + 32'(sent[g]);
         chk("rr_m_req_data", bus.m_req_data, exp_data);
         chk("rr_m_req_addr", 32'(bus.m_req_addr), 32'h40 + 32'(g));
         tick(1);
         bus.m_rsp_valid = 1'b1;
         bus.m_rsp_data  = ~exp_data;
         bus.m_rsp_op    = 2'd0;
         tick(1);
         bus.m_rsp_valid = 1'b0;
         chk("rr_s_rsp_valid", 32'(bus.s_rsp_valid), exp_oh);
         chk("rr_s_rsp_data",  bus.s_rsp_data[g], ~exp_data);
         bus.s_rsp_ready = 2'(exp_oh);
         tick(1);
         bus.s_rsp_ready = 2'b00;
      end

      // timeout: DM never answers; simultaneous clear loses to the set
      bus.s_req_addr[0] = 7'h12;
      bus.s_req_op[0]   = 2'd1;
      bus.s_req_valid   = 2'b01;
      wait_grant(0, "to_grant");
      tick(1);
      bus.s_req_valid = 2'b00;
      chk("to_m_req_valid", 32'(bus.m_req_valid), 32'd1);
      tick(1);
      bus.m_req_ready = 1'b0;
      chk("to_wait_m_rsp_ready", 32'(bus.m_rsp_ready), 32'd1);
      tick(254);
      chk("to_early_s_rsp_valid", 32'(bus.s_rsp_valid), 32'd0);
      chk("to_early_err",         32'(timeout_err), 32'd0);
      chk("to_early_busy",        32'(busy), 32'd1);
      timeout_clr = 1'b1;
      tick(1);
      timeout_clr = 1'b0;
      chk("to_s_rsp_valid",   32'(bus.s_rsp_valid), 32'd1);
      chk("to_s_rsp_data",    bus.s_rsp_data[0], 32'd0);
      chk("to_s_rsp_op",      32'(bus.s_rsp_op[0]), 32'd2);
      chk("to_err_set",       32'(timeout_err), 32'd1);
      chk("to_m_rsp_ready",   32'(bus.m_rsp_ready), 32'd0);
      bus.s_rsp_ready = 2'b01;
      tick(1);
      bus.s_rsp_ready = 2'b00;
      chk("late_idle_m_rsp_ready", 32'(bus.m_rsp_ready), 32'd1);
      bus.m_rsp_valid = 1'b1;
      bus.m_rsp_data  = 32'h0000_0055;
      bus.m_rsp_op    = 2'd0;
      tick(1);
      bus.m_rsp_valid = 1'b0;
      tick(2);
      chk("late_no_s_rsp_valid", 32'(bus.s_rsp_valid), 32'd0);
      chk("late_busy",           32'(busy), 32'd0);
      chk("err_sticky",          32'(timeout_err), 32'd1);
      timeout_clr = 1'b1;
      tick(1);
      timeout_clr = 1'b0;
      chk("err_cleared", 32'(timeout_err), 32'd0);

      // response arriving on the timeout edge wins
      bus.s_req_addr[1] = 7'h13;
      bus.s_req_op[1]   = 2'd1;
      bus.s_req_valid   = 2'b10;
      bus.m_req_ready   = 1'b1;
      wait_grant(1, "co_grant");
      tick(1);
      bus.s_req_valid = 2'b00;
      tick(1);
      bus.m_req_ready = 1'b0;
      tick(254);
      bus.m_rsp_valid = 1'b1;
      bus.m_rsp_data  = 32'h0BAD_BEEF;
      bus.m_rsp_op    = 2'd0;
      tick(1);
      bus.m_rsp_valid = 1'b0;
      chk("co_s_rsp_valid", 32'(bus.s_rsp_valid), 32'd2);
      chk("co_s_rsp_data",  bus.s_rsp_data[1], 32'h0BAD_BEEF);
      chk("co_s_rsp_op",    32'(bus.s_rsp_op[1]), 32'd0);
      chk("co_no_err",      32'(timeout_err), 32'd0);
      bus.s_rsp_ready = 2'b10;
      tick(1);
      bus.s_rsp_ready = 2'b00;
      chk("co_done_busy", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
